tl_tick_gen: RTL and testbench
==============================

TL_TICK_GEN -- requirements
Module: tl_tick_gen

Interface
REQ-001 The block SHALL have parameter DEB_LEN, default 4: number of consecutive clock edges a synchronised start input must differ from the debounced level before the level changes; legal range 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port ena, input, 1 bit: prescaler enable; it does not gate the debouncer.
REQ-005 The block SHALL have port div_sel, input, 8 bits: tick rate select, sampled every cycle.
REQ-006 The block SHALL have port start_in, input, 1 bit: raw asynchronous start/restart button.
REQ-007 The block SHALL have port tick, output, 1 bit: one-cycle clock-enable strobe that steps the downstream traffic-light FSM.
REQ-008 The block SHALL have port start_lvl, output, 1 bit: debounced start level.
REQ-009 The block SHALL have port start_pulse, output, 1 bit: one-cycle strobe on the debounced rising edge of start.
REQ-010 The block SHALL have port hb, output, 1 bit: heartbeat that toggles once per tick.

Function
REQ-011 The synchroniser SHALL be two flops, s1 then s2; start_in reaches s2 on the second clock edge.
REQ-012 Debounce counter SHALL be ceil(log2(DEB_LEN+1)) bits wide and SHALL clear on every edge where s2 equals start_lvl.
REQ-013 On each edge where s2 differs from start_lvl, the debounce counter SHALL increment; on the DEB_LEN-th consecutive such edge, start_lvl SHALL take s2 and the counter SHALL clear.
REQ-014 A glitch on s2 shorter than DEB_LEN cycles SHALL leave start_lvl unchanged and SHALL restart the count.
REQ-015 start_pulse SHALL be registered high for exactly the one cycle in which start_lvl has just changed 0->1; a 1->0 change SHALL NOT produce a pulse.
REQ-016 Prescaler SHALL be a 16-bit counter cnt with terminal value term = {div_sel, 8'hFF}.
REQ-017 With ena=1 and cnt >= term, the next edge SHALL set cnt to 0 and tick to 1; with ena=1 and cnt < term, the next edge SHALL increment cnt and set tick to 0.
REQ-018 With ena=0, cnt SHALL hold and tick SHALL be 0 on the next edge.
REQ-019 Tick period SHALL be (div_sel+1)*256 enabled cycles (256 cycles minimum, 65536 maximum); cnt SHALL never wrap through 16'hFFFF.
REQ-020 If div_sel decreases mid-count so that cnt > term, the next enabled edge SHALL assert tick and clear cnt (no 64K-cycle stall).
REQ-021 On the edge where start_lvl rises, cnt SHALL clear to 0 and tick SHALL be 0, regardless of ena or terminal count; this realigns the first tick after restart to a full period.
REQ-022 hb SHALL invert on every edge that sets tick to 1.
REQ-023 tick, start_pulse and hb SHALL be driven directly from flops, with no combinational path from any input to any output.

Reset
REQ-024 On an edge with rst_n=0, the following SHALL clear to 0: s1, s2, the debounce counter, start_lvl, start_pulse, cnt, tick and hb.
REQ-025 Reset SHALL take priority over all other behaviour, including a debounce completion in the same cycle.
REQ-026 After reset release, the first tick SHALL go high on the 256*(div_sel+1)-th enabled edge.

Verification
REQ-027 div_sel=0, ena=1, after reset -> tick high for one cycle at enabled edge 256, then every 256 cycles; hb toggles at each tick.
REQ-028 DEB_LEN=4, start_in 0->1 and held -> start_lvl and start_pulse rise at edge 6 after the change; start_pulse is low at edge 7; cnt=0 at edge 6.
REQ-029 DEB_LEN=4, start_in high for 3 cycles then low -> start_lvl and start_pulse stay 0.
REQ-030 div_sel=3 with cnt=600, then div_sel changed to 1 (term=511) -> tick on the next enabled edge, then a 512-cycle period.
REQ-031 ena low for 100 cycles mid-period -> tick delayed by exactly 100 cycles; no tick while ena is low.
REQ-032 rst_n low for one edge while start_lvl=1 and cnt=300 -> all outputs are 0 and cnt=0 on the next cycle; start_lvl re-qualifies only after 2+DEB_LEN edges.

Source files
------------

// File: rtl/tl_tick_gen.sv
// Traffic-light timebase: start-button synchroniser/debouncer plus a
// programmable prescaler that emits a one-cycle tick and a heartbeat.
module tl_tick_gen #(
  parameter int unsigned DEB_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] div_sel,
  input  logic       start_in,
  output logic       tick,
  output logic       start_lvl,
  output logic       start_pulse,
  output logic       hb
);

  localparam int unsigned DW = $clog2(DEB_LEN + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_LEN - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);

  logic          s1_q, s2_q;
  logic [DW-1:0] deb_q, deb_d;
  logic          lvl_q, lvl_d;
  logic          pulse_q, pulse_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          hb_q, hb_d;
  logic [15:0]   term;
  logic          deb_done;
  logic          rise;

  always_comb begin
    term     = {div_sel, 8'hFF};
    deb_done = (s2_q != lvl_q) && (deb_q == DEB_LAST);
    rise     = deb_done && s2_q;

    deb_d   = deb_q + DEB_ONE;
    if ((s2_q == lvl_q) || deb_done) deb_d = '0;
    lvl_d   = deb_done ? s2_q : lvl_q;
    pulse_d = rise;

    cnt_d  = cnt_q;
    tick_d = 1'b0;
    hb_d   = hb_q;
    // A fresh start realigns the period so the first tick is a full one.
    if (rise) begin
      cnt_d = '0;
    end else if (ena) begin
      if (cnt_q >= term) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        hb_d   = ~hb_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      deb_q   <= '0;
      lvl_q   <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      hb_q    <= 1'b0;
    end else begin
      s1_q    <= start_in;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      hb_q    <= hb_d;
    end
  end

  assign tick        = tick_q;
  assign start_lvl   = lvl_q;
  assign start_pulse = pulse_q;
  assign hb          = hb_q;

endmodule

// File: tb/tb_tl_tick_gen.sv
// Directed bench for tl_tick_gen: tick timing, debounce, realignment
// and reset, with expectations queued before each driven edge.
module tb_tl_tick_gen;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] div_sel;
  logic       start_in;
  logic       tick;
  logic       start_lvl;
  logic       start_pulse;
  logic       hb;

  typedef struct {
    string tag;
    logic  t;
    logic  l;
    logic  p;
    logic  h;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_hb = 1'b0;

  tl_tick_gen #(.DEB_LEN(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .div_sel    (div_sel),
    .start_in   (start_in),
    .tick       (tick),
    .start_lvl  (start_lvl),
    .start_pulse(start_pulse),
    .hb         (hb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue the expectation, drive one edge, then pop and compare.
  task automatic expect_step(input string tag, input logic t,
                             input logic l, input logic p);
    exp_t e;
    if (t) exp_hb = ~exp_hb;
    sb.push_back('{tag, t, l, p, exp_hb});
    step();
    e = sb.pop_front();
    check({e.tag, ".tick"}, 32'(tick), 32'(e.t));
    check({e.tag, ".lvl"}, 32'(start_lvl), 32'(e.l));
    check({e.tag, ".pulse"}, 32'(start_pulse), 32'(e.p));
    check({e.tag, ".hb"}, 32'(hb), 32'(e.h));
  endtask

  // n edges with no tick, no pulse, steady level and heartbeat.
  task automatic quiet(input string tag, input int n, input logic l);
    int nt = 0;
    int np = 0;
    int nl = 0;
    int nh = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (tick !== 1'b0) nt++;
      if (start_pulse !== 1'b0) np++;
      if (start_lvl !== l) nl++;
      if (hb !== exp_hb) nh++;
    end
    check({tag, ".ticks"}, 32'(nt), 32'd0);
    check({tag, ".pulses"}, 32'(np), 32'd0);
    check({tag, ".lvl_bad"}, 32'(nl), 32'd0);
    check({tag, ".hb_bad"}, 32'(nh), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    ena      = 1'b1;
    div_sel  = 8'd0;
    start_in = 1'b0;
    step();
    step();
    expect_step("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // First tick on enabled edge 256, then every 256.
    quiet("p0_first", 255, 1'b0);
    expect_step("p0_tick1", 1'b1, 1'b0, 1'b0);
    quiet("p0_gap", 255, 1'b0);
    expect_step("p0_tick2", 1'b1, 1'b0, 1'b0);

    // 100 disabled cycles stretch the period by 100.
    quiet("ena_pre", 100, 1'b0);
    ena = 1'b0;
    quiet("ena_off", 100, 1'b0);
    ena = 1'b1;
    quiet("ena_post", 155, 1'b0);
    expect_step("ena_tick", 1'b1, 1'b0, 1'b0);

    // Shrinking term below cnt fires immediately.
    div_sel = 8'd3;
    quiet("div_600", 600, 1'b0);
    div_sel = 8'd1;
    expect_step("div_tick", 1'b1, 1'b0, 1'b0);
    quiet("div_gap", 511, 1'b0);
    expect_step("div_tick2", 1'b1, 1'b0, 1'b0);

    // Park cnt at 200 with prescaler disabled.
    quiet("pre_deb", 200, 1'b0);
    ena     = 1'b0;
    div_sel = 8'd0;

    // 3-cycle glitch is rejected.
    start_in = 1'b1;
    for (int i = 0; i < 3; i++) expect_step("glitch", 1'b0, 1'b0, 1'b0);
    start_in = 1'b0;
    quiet("glitch_tail", 10, 1'b0);

    // Held press qualifies on edge 6, pulse on edge 6 only.
    start_in = 1'b1;
    for (int i = 0; i < 5; i++) expect_step("rise_wait", 1'b0, 1'b0, 1'b0);
    expect_step("rise_edge6", 1'b0, 1'b1, 1'b1);
    ena = 1'b1;
    expect_step("rise_edge7", 1'b0, 1'b1, 1'b0);
    quiet("rise_realign", 254, 1'b1);
    expect_step("rise_tick", 1'b1, 1'b1, 1'b0);

    // Release: level falls on edge 6, no pulse.
    start_in = 1'b0;
    for (int i = 0; i < 5; i++) expect_step("fall_wait", 1'b0, 1'b1, 1'b0);
    expect_step("fall_edge6", 1'b0, 1'b0, 1'b0);

    // Re-press, then park cnt at 300.
    start_in = 1'b1;
    for (int i = 0; i < 5; i++) expect_step("rep_wait", 1'b0, 1'b0, 1'b0);
    expect_step("rep_edge6", 1'b0, 1'b1, 1'b1);
    div_sel = 8'd3;
    quiet("hold300", 300, 1'b1);

    // One-edge reset clears everything.
    rst_n  = 1'b0;
    exp_hb = 1'b0;
    expect_step("rst_mid", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Reset wins over a debounce completing on the same edge.
    for (int i = 0; i < 5; i++) expect_step("prio_wait", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    expect_step("rst_prio", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Requalifies after 2+DEB_LEN edges, then a full period.
    div_sel = 8'd0;
    for (int i = 0; i < 5; i++) expect_step("req_wait", 1'b0, 1'b0, 1'b0);
    expect_step("req_edge6", 1'b0, 1'b1, 1'b1);
    quiet("req_period", 255, 1'b1);
    expect_step("req_tick", 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
